// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller and the pipeline buffers
// that sit around it: state encodings, the register-address width default and
// a small constant helper used for sizing counters.
package hazard_stall_ctrl_pkg;

    // Register-address width shared with the ID/EX and EX/MEM buffers.
    localparam int REG_ADDR_W_DEFAULT = 4;

    // Controller states. The encodings are fixed so that waveforms and the
    // neighbouring buffers can decode them directly.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RET   = 2'd3
    } hazard_state_e;

    // Larger of two integers, for sizing counters at elaboration time.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use detector. Flags the case where the instruction in EX
// is a load whose destination is read as an operand by the instruction in ID.
// Kept separate so the forwarding unit can reuse the same compare.
module hazard_load_use_cmp
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic              mem_read_i,
    input  logic              reg_write_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic              uses_src_i,
    input  logic              uses_dst_i,
    output logic              load_use_o
);

    logic srcMatch;
    logic dstMatch;

    // Exact compare over every address bit; no register gets special treatment,
    // so a load into register 0 still stalls a dependent reader.
    assign srcMatch   = uses_src_i && (src_addr_i == dest_addr_i);
    assign dstMatch   = uses_dst_i && (dst_addr_i == dest_addr_i);
    assign load_use_o = mem_read_i && reg_write_i && (srcMatch || dstMatch);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside the ID/EX buffer. Looks at the EX-stage copy
// of the control fields and the instruction now in ID, and drives the PC and
// IF/ID write-enables plus the IF/ID and ID/EX flushes for three situations:
// a load-use bubble, a taken-branch flush and the multi-cycle RET/RTI drain.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int FLUSH_CYC  = 2,
    parameter int RET_CYC    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_reg_write_i,
    input  logic [REG_ADDR_W-1:0] ex_dest_addr_i,
    input  logic [REG_ADDR_W-1:0] id_src_addr_i,
    input  logic [REG_ADDR_W-1:0] id_dst_addr_i,
    input  logic                  id_uses_src_i,
    input  logic                  id_uses_dst_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  ex_ret_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  busy_o
);

    // Counter is just wide enough for the longer of the two multi-cycle
    // sequences; it only ever counts down to 1, so it never wraps.
    localparam int CNT_W = $clog2(maxInt(FLUSH_CYC, RET_CYC) + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] RET_LOAD   = CNT_W'(RET_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    hazard_state_e    state_q;
    hazard_state_e    state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic loadUse;
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexFlush;

    hazard_load_use_cmp #(
        .ADDR_W (REG_ADDR_W)
    ) u_load_use_cmp (
        .mem_read_i  (ex_mem_read_i),
        .reg_write_i (ex_reg_write_i),
        .dest_addr_i (ex_dest_addr_i),
        .src_addr_i  (id_src_addr_i),
        .dst_addr_i  (id_dst_addr_i),
        .uses_src_i  (id_uses_src_i),
        .uses_dst_i  (id_uses_dst_i),
        .load_use_o  (loadUse)
    );

    // Output decode and next-state logic. A taken branch always wins, then
    // RET, then load-use; the flush and drain sequences ignore load-use because
    // the instructions they hold are being squashed anyway.
    always_comb begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        state_d   = state_q;
        count_d   = count_q;

        unique case (state_q)
            ST_RUN, ST_LU: begin
                if (ex_branch_taken_i) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = ST_FLUSH;
                        count_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        count_d = CNT_ZERO;
                    end
                end else if (ex_ret_i) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    idexFlush = 1'b1;
                    if (RET_CYC > 1) begin
                        state_d = ST_RET;
                        count_d = RET_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        count_d = CNT_ZERO;
                    end
                end else if ((state_q == ST_RUN) && loadUse) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    idexFlush = 1'b1;
                    state_d   = ST_LU;
                    count_d   = CNT_ZERO;
                end else begin
                    state_d = ST_RUN;
                    count_d = CNT_ZERO;
                end
            end

            ST_FLUSH: begin
                ifidFlush = 1'b1;
                idexFlush = 1'b1;
                if (ex_branch_taken_i && (FLUSH_CYC > 1)) begin
                    count_d = FLUSH_LOAD;
                end else if (count_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                    count_d = CNT_ZERO;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end

            ST_RET: begin
                if (ex_branch_taken_i) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = ST_FLUSH;
                        count_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        count_d = CNT_ZERO;
                    end
                end else begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    idexFlush = 1'b1;
                    if (count_q <= CNT_ONE) begin
                        state_d = ST_RUN;
                        count_d = CNT_ZERO;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                count_d = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers; reset drops straight back to RUN so any
    // stall or flush in progress is abandoned immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            count_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign pc_write_o   = pcWrite;
    assign ifid_write_o = ifidWrite;
    assign ifid_flush_o = ifidFlush;
    assign idex_flush_o = idexFlush;
    assign busy_o       = (state_q != ST_RUN);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with default parameters
// (REG_ADDR_W=4, FLUSH_CYC=2, RET_CYC=3). Expected output patterns are
// written as {pc_write, ifid_write, ifid_flush, idex_flush, busy}.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic       exMemRead;
    logic       exRegWrite;
    logic [3:0] exDestAddr;
    logic [3:0] idSrcAddr;
    logic [3:0] idDstAddr;
    logic       idUsesSrc;
    logic       idUsesDst;
    logic       exBranchTaken;
    logic       exRet;
    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexFlush;
    logic       busy;

    int nAsserts  = 0;
    int nFailures = 0;

    localparam logic [4:0] PASS_THRU = 5'b11000;
    localparam logic [4:0] LU_BUBBLE = 5'b00010;
    localparam logic [4:0] LU_HELD   = 5'b11001;
    localparam logic [4:0] BR_ENTRY  = 5'b11110;
    localparam logic [4:0] BR_BUSY   = 5'b11111;
    localparam logic [4:0] RET_ENTRY = 5'b00010;
    localparam logic [4:0] RET_BUSY  = 5'b00011;

    hazard_stall_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_mem_read_i     (exMemRead),
        .ex_reg_write_i    (exRegWrite),
        .ex_dest_addr_i    (exDestAddr),
        .id_src_addr_i     (idSrcAddr),
        .id_dst_addr_i     (idDstAddr),
        .id_uses_src_i     (idUsesSrc),
        .id_uses_dst_i     (idUsesDst),
        .ex_branch_taken_i (exBranchTaken),
        .ex_ret_i          (exRet),
        .pc_write_o        (pcWrite),
        .ifid_write_o      (ifidWrite),
        .ifid_flush_o      (ifidFlush),
        .idex_flush_o      (idexFlush),
        .busy_o            (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge, well away from the
    // rising edge that updates the controller state.
    task automatic applyStimulus(input logic mr, input logic rw, input logic [3:0] dest,
                                 input logic [3:0] src, input logic [3:0] dst,
                                 input logic us, input logic ud,
                                 input logic br, input logic ret);
        @(negedge clk);
        exMemRead     = mr;
        exRegWrite    = rw;
        exDestAddr    = dest;
        idSrcAddr     = src;
        idDstAddr     = dst;
        idUsesSrc     = us;
        idUsesDst     = ud;
        exBranchTaken = br;
        exRet         = ret;
    endtask

    // Let the combinational outputs settle, then compare against the
    // hand-computed pattern.
    task automatic checkOutput(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        #1;
        observed = {pcWrite, ifidWrite, ifidFlush, idexFlush, busy};
        nAsserts++;
        assert (observed === expected)
        else begin
            nFailures++;
            $error("[TB] FAIL %s observed=%b expected=%b (pc,ifidW,ifidF,idexF,busy)",
                   tag, observed, expected);
        end
    endtask

    // Directed sequence covering load-use, branch flush, RET drain,
    // priorities and asynchronous reset.
    initial begin
        rst_n         = 1'b0;
        exMemRead     = 1'b0;
        exRegWrite    = 1'b0;
        exDestAddr    = 4'd0;
        idSrcAddr     = 4'd0;
        idDstAddr     = 4'd0;
        idUsesSrc     = 1'b0;
        idUsesDst     = 1'b0;
        exBranchTaken = 1'b0;
        exRet         = 1'b0;

        #2;
        checkOutput("reset_values", PASS_THRU);
        repeat (2) @(posedge clk);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        checkOutput("idle_after_reset", PASS_THRU);

        // Load-use on the source operand: one bubble, then RUN defaults
        // even though the dependency is still visible on the inputs.
        applyStimulus(1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0);
        checkOutput("lu_src_bubble", LU_BUBBLE);
        applyStimulus(1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0);
        checkOutput("lu_src_held", LU_HELD);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_src_back_run", PASS_THRU);

        // Near misses that must not stall.
        applyStimulus(1, 1, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0);
        checkOutput("no_hz_src_unused", PASS_THRU);
        applyStimulus(1, 1, 4'd3, 4'd2, 4'd0, 1, 0, 0, 0);
        checkOutput("no_hz_addr_diff", PASS_THRU);
        applyStimulus(1, 0, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0);
        checkOutput("no_hz_no_regwrite", PASS_THRU);
        applyStimulus(0, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0);
        checkOutput("no_hz_no_memread", PASS_THRU);
        applyStimulus(1, 1, 4'hF, 4'h7, 4'h7, 1, 1, 0, 0);
        checkOutput("no_hz_msb_diff", PASS_THRU);
        applyStimulus(1, 1, 4'd9, 4'd1, 4'd9, 1, 0, 0, 0);
        checkOutput("no_hz_dst_unused", PASS_THRU);

        // Register 0 is not special.
        applyStimulus(1, 1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0);
        checkOutput("lu_reg0_bubble", LU_BUBBLE);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_reg0_held", LU_HELD);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_reg0_back_run", PASS_THRU);

        // Load-use through the destination-as-operand path.
        applyStimulus(1, 1, 4'd5, 4'd1, 4'd5, 1, 1, 0, 0);
        checkOutput("lu_dst_bubble", LU_BUBBLE);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_dst_held", LU_HELD);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_dst_back_run", PASS_THRU);

        // Taken branch: two flush cycles, busy only in the second.
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
        checkOutput("br_cycle1", BR_ENTRY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("br_cycle2", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("br_done", PASS_THRU);

        // Branch and load-use together: flush only, lu ignored in FLUSH.
        applyStimulus(1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 1, 0);
        checkOutput("prio_br_lu_c1", BR_ENTRY);
        applyStimulus(1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0);
        checkOutput("prio_br_lu_c2", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("prio_br_lu_done", PASS_THRU);

        // RET drain: fetch held for three cycles.
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);
        checkOutput("ret_cycle1", RET_ENTRY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("ret_cycle2", RET_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("ret_cycle3", RET_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("ret_done", PASS_THRU);

        // RET interrupted by a branch in its second cycle.
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);
        checkOutput("ret_br_c1", RET_ENTRY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
        checkOutput("ret_br_c2", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("ret_br_c3", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("ret_br_done", PASS_THRU);

        // RET arriving during a flush is squashed.
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
        checkOutput("br_ret_c1", BR_ENTRY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);
        checkOutput("br_ret_c2", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("br_ret_done", PASS_THRU);

        // Branch arriving while the load-use instruction is held.
        applyStimulus(1, 1, 4'd6, 4'd6, 4'd0, 1, 0, 0, 0);
        checkOutput("lu_br_c1", LU_BUBBLE);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
        checkOutput("lu_br_c2", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_br_c3", BR_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("lu_br_done", PASS_THRU);

        // Asynchronous reset in the middle of a RET drain.
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);
        checkOutput("rst_ret_c1", RET_ENTRY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("rst_ret_c2", RET_BUSY);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        rst_n = 1'b0;
        checkOutput("rst_mid_ret", PASS_THRU);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        checkOutput("rst_release", PASS_THRU);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("rst_passthru", PASS_THRU);
        applyStimulus(1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0);
        checkOutput("rst_then_lu", LU_BUBBLE);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("rst_then_lu_held", LU_HELD);
        applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        checkOutput("rst_then_lu_done", PASS_THRU);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
        $finish;
    end

endmodule
